alu_rs_scheduler: RTL

Reservation station and issue scheduler for the integer ALU. It buffers up to RS_SIZE dispatched ALU/branch operations. It wakes pending operands by snooping the ALU and load/store result buses, and issues at most one ready operation per cycle onto the ALU's mission interface. It sits between the decoder/dispatch stage and the combinational ALU, and tracks ROB tags only.

---
 rtl/alu_rs_scheduler_pkg.sv | 91 +++++++++
 rtl/alu_rs_scheduler_if.sv | 58 +++++
 rtl/alu_rs_scheduler_pick_lowest.sv | 19 +
 rtl/alu_rs_scheduler.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared types and op-type codes for the ALU reservation station.
// The ALU imports the same op constants.
package alu_rs_scheduler_pkg;

  localparam int XLEN        = 32;
  localparam int OP_W        = 6;
  localparam int ROB_W       = 4;
  localparam int RS_SIZE_DEF = 8;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [ROB_W-1:0] tag_t;
  typedef logic [XLEN-1:0]  data_t;

  localparam op_t OP_LUI   = 6'd1;
  localparam op_t OP_AUIPC = 6'd2;
  localparam op_t OP_JAL   = 6'd3;
  localparam op_t OP_JALR  = 6'd4;
  localparam op_t OP_BEQ   = 6'd5;
  localparam op_t OP_BNE   = 6'd6;
  localparam op_t OP_BLT   = 6'd7;
  localparam op_t OP_BGE   = 6'd8;
  localparam op_t OP_BLTU  = 6'd9;
  localparam op_t OP_BGEU  = 6'd10;
  localparam op_t OP_LB    = 6'd11;
  localparam op_t OP_LH    = 6'd12;
  localparam op_t OP_LW    = 6'd13;
  localparam op_t OP_LBU   = 6'd14;
  localparam op_t OP_LHU   = 6'd15;
  localparam op_t OP_SB    = 6'd16;
  localparam op_t OP_SH    = 6'd17;
  localparam op_t OP_SW    = 6'd18;
  localparam op_t OP_ADDI  = 6'd19;
  localparam op_t OP_SLTI  = 6'd20;
  localparam op_t OP_SLTIU = 6'd21;
  localparam op_t OP_XORI  = 6'd22;
  localparam op_t OP_ORI   = 6'd23;
  localparam op_t OP_ANDI  = 6'd24;
  localparam op_t OP_SLLI  = 6'd25;
  localparam op_t OP_SRLI  = 6'd26;
  localparam op_t OP_SRAI  = 6'd27;
  localparam op_t OP_ADD   = 6'd28;
  localparam op_t OP_SUB   = 6'd29;
  localparam op_t OP_SLL   = 6'd30;
  localparam op_t OP_SLT   = 6'd31;
  localparam op_t OP_SLTU  = 6'd32;
  localparam op_t OP_XOR   = 6'd33;
  localparam op_t OP_SRL   = 6'd34;
  localparam op_t OP_SRA   = 6'd35;
  localparam op_t OP_OR    = 6'd36;
  localparam op_t OP_AND   = 6'd37;

  typedef struct packed {
    logic  busy;
    op_t   op;
    data_t vj;
    data_t vk;
    logic  qj_busy;
    tag_t  qj;
    logic  qk_busy;
    tag_t  qk;
    tag_t  dest;
  } rs_entry_t;

  typedef struct packed {
    logic  hit;
    data_t val;
  } snoop_t;

  // ALU bus wins when both buses carry the tag
  function automatic snoop_t cdb_snoop(
    input tag_t  q,
    input logic  a_v,
    input tag_t  a_t,
    input data_t a_d,
    input logic  l_v,
    input tag_t  l_t,
    input data_t l_d
  );
    snoop_t s;
    s = '0;
    if (a_v && a_t == q) begin
      s.hit = 1'b1;
      s.val = a_d;
    end else if (l_v && l_t == q) begin
      s.hit = 1'b1;
      s.val = l_d;
    end
    return s;
  endfunction

endpackage

// File: rtl/alu_rs_scheduler_if.sv
// Dispatch, result-bus and ALU-issue signals of the ALU reservation station.
interface alu_rs_scheduler_if;
  import alu_rs_scheduler_pkg::*;

  logic  dispatch_valid;
  op_t   dispatch_op;
  data_t dispatch_vj;
  data_t dispatch_vk;
  logic  dispatch_qj_busy;
  logic  dispatch_qk_busy;
  tag_t  dispatch_qj;
  tag_t  dispatch_qk;
  tag_t  dispatch_dest;
  logic  rs_full;

  logic  cdb_alu_valid;
  tag_t  cdb_alu_tag;
  data_t cdb_alu_value;
  logic  cdb_lsb_valid;
  tag_t  cdb_lsb_tag;
  data_t cdb_lsb_value;

  logic  alu_mission;
  op_t   alu_op_type;
  data_t alu_rs1;
  data_t alu_rs2;
  tag_t  alu_rob_dest;

  modport master (
    output dispatch_valid, dispatch_op,
    output dispatch_vj, dispatch_vk,
    output dispatch_qj_busy, dispatch_qk_busy,
    output dispatch_qj, dispatch_qk,
    output dispatch_dest,
    output cdb_alu_valid, cdb_alu_tag,
    output cdb_alu_value,
    output cdb_lsb_valid, cdb_lsb_tag,
    output cdb_lsb_value,
    input  rs_full,
    input  alu_mission, alu_op_type,
    input  alu_rs1, alu_rs2, alu_rob_dest
  );

  modport slave (
    input  dispatch_valid, dispatch_op,
    input  dispatch_vj, dispatch_vk,
    input  dispatch_qj_busy, dispatch_qk_busy,
    input  dispatch_qj, dispatch_qk,
    input  dispatch_dest,
    input  cdb_alu_valid, cdb_alu_tag,
    input  cdb_alu_value,
    input  cdb_lsb_valid, cdb_lsb_tag,
    input  cdb_lsb_value,
    output rs_full,
    output alu_mission, alu_op_type,
    output alu_rs1, alu_rs2, alu_rob_dest
  );
endinterface

// File: rtl/alu_rs_scheduler_pick_lowest.sv
// Lowest-set-bit priority encoder: found flag plus index.
module rs_pick_lowest #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers dispatched ops, snoops both
// result buses, issues the lowest-index ready entry each cycle.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF
) (
  input logic            clk,
  input logic            rst,
  input logic            rdy,
  input logic            flush,
  alu_rs_scheduler_if.slave bus
);

  localparam int IW = $clog2(RS_SIZE);

  rs_entry_t rs_q [RS_SIZE];

  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found;
  logic               ready_found;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      ready_idx;

  snoop_t    wj [RS_SIZE];
  snoop_t    wk [RS_SIZE];
  snoop_t    dj;
  snoop_t    dk;
  rs_entry_t new_e;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = !rs_q[i].busy;
      ready_vec[i] = rs_q[i].busy
                  && !rs_q[i].qj_busy
                  && !rs_q[i].qk_busy;
      wj[i] = cdb_snoop(rs_q[i].qj,
        bus.cdb_alu_valid, bus.cdb_alu_tag,
        bus.cdb_alu_value,
        bus.cdb_lsb_valid, bus.cdb_lsb_tag,
        bus.cdb_lsb_value);
      wk[i] = cdb_snoop(rs_q[i].qk,
        bus.cdb_alu_valid, bus.cdb_alu_tag,
        bus.cdb_alu_value,
        bus.cdb_lsb_valid, bus.cdb_lsb_tag,
        bus.cdb_lsb_value);
    end
  end

  rs_pick_lowest #(.N(RS_SIZE)) u_pick_free (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick_lowest #(.N(RS_SIZE)) u_pick_ready (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  assign bus.rs_full = !free_found;

  // Operands pending on a tag broadcast this cycle enter resolved
  always_comb begin
    dj = cdb_snoop(bus.dispatch_qj,
      bus.cdb_alu_valid, bus.cdb_alu_tag,
      bus.cdb_alu_value,
      bus.cdb_lsb_valid, bus.cdb_lsb_tag,
      bus.cdb_lsb_value);
    dk = cdb_snoop(bus.dispatch_qk,
      bus.cdb_alu_valid, bus.cdb_alu_tag,
      bus.cdb_alu_value,
      bus.cdb_lsb_valid, bus.cdb_lsb_tag,
      bus.cdb_lsb_value);
    new_e         = '0;
    new_e.busy    = 1'b1;
    new_e.op      = bus.dispatch_op;
    new_e.dest    = bus.dispatch_dest;
    new_e.qj      = bus.dispatch_qj;
    new_e.qk      = bus.dispatch_qk;
    new_e.vj      = bus.dispatch_vj;
    new_e.vk      = bus.dispatch_vk;
    new_e.qj_busy = bus.dispatch_qj_busy;
    new_e.qk_busy = bus.dispatch_qk_busy;
    if (bus.dispatch_qj_busy && dj.hit) begin
      new_e.vj      = dj.val;
      new_e.qj_busy = 1'b0;
    end
    if (bus.dispatch_qk_busy && dk.hit) begin
      new_e.vk      = dk.val;
      new_e.qk_busy = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) rs_q[i] <= '0;
      bus.alu_mission  <= 1'b0;
      bus.alu_op_type  <= '0;
      bus.alu_rs1      <= '0;
      bus.alu_rs2      <= '0;
      bus.alu_rob_dest <= '0;
    end else if (!rdy) begin
      bus.alu_mission <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) rs_q[i].busy <= 1'b0;
      bus.alu_mission <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (rs_q[i].busy && rs_q[i].qj_busy && wj[i].hit) begin
          rs_q[i].vj      <= wj[i].val;
          rs_q[i].qj_busy <= 1'b0;
        end
        if (rs_q[i].busy && rs_q[i].qk_busy && wk[i].hit) begin
          rs_q[i].vk      <= wk[i].val;
          rs_q[i].qk_busy <= 1'b0;
        end
      end
      bus.alu_mission <= ready_found;
      if (ready_found) begin
        bus.alu_op_type       <= rs_q[ready_idx].op;
        bus.alu_rs1           <= rs_q[ready_idx].vj;
        bus.alu_rs2           <= rs_q[ready_idx].vk;
        bus.alu_rob_dest      <= rs_q[ready_idx].dest;
        rs_q[ready_idx].busy  <= 1'b0;
      end
      // Free slot comes from registered state, never the issuing entry
      if (bus.dispatch_valid && free_found) begin
        rs_q[free_idx] <= new_e;
      end
    end
  end

endmodule
